// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown sequencer slice.
package countdown_pkg;

  // Sequencer states; the encoding is fixed so debug taps stay meaningful.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int min_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between the countdown sequencer and game logic.
//
// Handshake: there is no valid/ready pair here. start and abort are
// single-cycle requests sampled on every rising clock edge. pause is a
// level. All status outputs are registered and change only on a clock edge
// (or immediately on reset).
interface countdown_sequencer_if
  import countdown_pkg::*;
#(
  parameter int NUM_STEPS = 4
) ();

  localparam int IDX_W = min_width(NUM_STEPS);

  logic                 start;
  logic                 abort;
  logic                 pause;
  logic                 repeat_mode;
  logic [IDX_W-1:0]     step_idx;
  logic [NUM_STEPS-1:0] anode_n;
  logic                 countdown_in_action;
  logic                 countdown_done;
  logic                 done_pulse;
  logic                 wrap_pulse;
  state_t               state_dbg;

  modport master (
    output start, abort, pause, repeat_mode,
    input  step_idx, anode_n, countdown_in_action, countdown_done,
    input  done_pulse, wrap_pulse, state_dbg
  );

  modport slave (
    input  start, abort, pause, repeat_mode,
    output step_idx, anode_n, countdown_in_action, countdown_done,
    output done_pulse, wrap_pulse, state_dbg
  );

endinterface

// File: rtl/countdown_anode_decode.sv
// Registered active-low one-hot digit select.
// Fed with the next-state index/enable so the registered select lines up
// with the registered step index in the same cycle.
module countdown_anode_decode
  import countdown_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  localparam int IDX_W = min_width(NUM_STEPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     idx_d,
  input  logic                 en_d,
  output logic [NUM_STEPS-1:0] anode_n
);

  logic [NUM_STEPS-1:0] anode_n_d, anode_n_q;

  // Decode the next index into an active-low one-hot; all ones when disabled.
  always_comb begin
    anode_n_d = '1;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (en_d && (idx_d == IDX_W'(i))) anode_n_d[i] = 1'b0;
    end
  end

  // Register the select so the output is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) anode_n_q <= '1;
    else     anode_n_q <= anode_n_d;
  end

  assign anode_n = anode_n_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown sequencer: walks step_idx through NUM_STEPS steps, holding each
// for TICKS_PER_STEP clocks, with one-shot/repeat, pause and abort.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int NUM_STEPS      = 4,
  parameter int TICKS_PER_STEP = 1
) (
  input  logic                  clk_countdown,
  input  logic                  rst,
  countdown_sequencer_if.slave  bus
);

  localparam int IDX_W  = min_width(NUM_STEPS);
  localparam int TICK_W = min_width(TICKS_PER_STEP);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STEPS - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_STEP - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  step_idx_q, step_idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              repeat_q, repeat_d;
  logic              in_action_q, in_action_d;
  logic              done_q, done_d;
  logic              done_pulse_q, done_pulse_d;
  logic              wrap_pulse_q, wrap_pulse_d;

  // Next-state logic. Priority: abort > start > pause > tick.
  // A PAUSED cycle with pause released counts a tick on that same edge, so
  // every edge that samples pause high costs exactly one cycle.
  always_comb begin
    state_d      = state_q;
    step_idx_d   = step_idx_q;
    tick_d       = tick_q;
    repeat_d     = repeat_q;
    done_pulse_d = 1'b0;
    wrap_pulse_d = 1'b0;

    if (bus.abort) begin
      state_d    = IDLE;
      step_idx_d = '0;
      tick_d     = '0;
    end else if (bus.start) begin
      state_d    = bus.pause ? PAUSED : RUN;
      step_idx_d = '0;
      tick_d     = '0;
      repeat_d   = bus.repeat_mode;
    end else if ((state_q == RUN) || (state_q == PAUSED)) begin
      if (bus.pause) begin
        state_d = PAUSED;
      end else begin
        state_d = RUN;
        if (tick_q == LAST_TICK) begin
          tick_d = '0;
          if (step_idx_q != LAST_IDX) begin
            step_idx_d = step_idx_q + IDX_W'(1);
          end else if (repeat_q) begin
            step_idx_d   = '0;
            wrap_pulse_d = 1'b1;
          end else begin
            state_d      = DONE;
            done_pulse_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
    end

    in_action_d = (state_d == RUN) || (state_d == PAUSED);
    done_d      = (state_d == DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge clk_countdown or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      step_idx_q   <= '0;
      tick_q       <= '0;
      repeat_q     <= 1'b0;
      in_action_q  <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_idx_q   <= step_idx_d;
      tick_q       <= tick_d;
      repeat_q     <= repeat_d;
      in_action_q  <= in_action_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  countdown_anode_decode #(
    .NUM_STEPS (NUM_STEPS)
  ) u_anode_decode (
    .clk     (clk_countdown),
    .rst     (rst),
    .idx_d   (step_idx_d),
    .en_d    (in_action_d),
    .anode_n (bus.anode_n)
  );

  assign bus.step_idx            = step_idx_q;
  assign bus.countdown_in_action = in_action_q;
  assign bus.countdown_done      = done_q;
  assign bus.done_pulse          = done_pulse_q;
  assign bus.wrap_pulse          = wrap_pulse_q;
  assign bus.state_dbg           = state_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer across three parameter sets:
// A (N=4,T=1), B (N=6,T=3, repeat), C (N=4,T=2, pause).
module tb_countdown_sequencer;
  import countdown_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  countdown_sequencer_if #(.NUM_STEPS(4)) if_a ();
  countdown_sequencer_if #(.NUM_STEPS(6)) if_b ();
  countdown_sequencer_if #(.NUM_STEPS(4)) if_c ();

  countdown_sequencer #(.NUM_STEPS(4), .TICKS_PER_STEP(1)) u_a (
    .clk_countdown (clk), .rst (rst), .bus (if_a.slave));
  countdown_sequencer #(.NUM_STEPS(6), .TICKS_PER_STEP(3)) u_b (
    .clk_countdown (clk), .rst (rst), .bus (if_b.slave));
  countdown_sequencer #(.NUM_STEPS(4), .TICKS_PER_STEP(2)) u_c (
    .clk_countdown (clk), .rst (rst), .bus (if_c.slave));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_a.start = 0; if_a.abort = 0; if_a.pause = 0; if_a.repeat_mode = 0;
    if_b.start = 0; if_b.abort = 0; if_b.pause = 0; if_b.repeat_mode = 0;
    if_c.start = 0; if_c.abort = 0; if_c.pause = 0; if_c.repeat_mode = 0;
  endtask

  int pulses;
  logic done_seen;

  initial begin
    rst = 1'b1;
    idle_inputs();
    #12;
    // Reset values on every instance.
    check_eq("rst_a_idx", if_a.step_idx, 0);
    check_eq("rst_a_anode", if_a.anode_n, 4'b1111);
    check_eq("rst_a_act", if_a.countdown_in_action, 0);
    check_eq("rst_b_anode", if_b.anode_n, 6'b111111);
    check_eq("rst_c_done", if_c.countdown_done, 0);
    check_eq("rst_c_state", if_c.state_dbg, IDLE);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---- Test 1: defaults one-shot ----
    for (int i = 0; i < 4; i++) exp_q.push_back({24'd0, 4'(i), ~(4'b0001 << i)});
    if_a.start = 1; tick(); if_a.start = 0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check_eq("t1_idx", if_a.step_idx, e[7:4]);
      check_eq("t1_anode", if_a.anode_n, e[3:0]);
      check_eq("t1_act", if_a.countdown_in_action, 1);
      tick();
    end
    check_eq("t1_done_pulse", if_a.done_pulse, 1);
    check_eq("t1_done", if_a.countdown_done, 1);
    check_eq("t1_anode_off", if_a.anode_n, 4'b1111);
    check_eq("t1_act_off", if_a.countdown_in_action, 0);
    check_eq("t1_idx_hold", if_a.step_idx, 3);
    tick();
    check_eq("t1_pulse_1cyc", if_a.done_pulse, 0);
    check_eq("t1_done_sticky", if_a.countdown_done, 1);
    if_a.pause = 1; tick(); if_a.pause = 0;
    check_eq("t1_pause_in_done", if_a.state_dbg, DONE);

    // ---- Test 2: N=6 T=3 repeat, abort at cycle 25 ----
    if_b.repeat_mode = 1; if_b.start = 1; tick(); if_b.start = 0; if_b.repeat_mode = 0;
    done_seen = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      check_eq($sformatf("t2_wrap_c%0d", c), if_b.wrap_pulse, (c == 18));
      check_eq($sformatf("t2_idx_c%0d", c), if_b.step_idx, (c / 3) % 6);
      if (if_b.countdown_done || if_b.done_pulse) done_seen = 1;
    end
    check_eq("t2_never_done", done_seen, 0);
    if_b.abort = 1; tick(); if_b.abort = 0;
    check_eq("t2_abort_state", if_b.state_dbg, IDLE);
    check_eq("t2_abort_idx", if_b.step_idx, 0);
    check_eq("t2_abort_act", if_b.countdown_in_action, 0);
    check_eq("t2_abort_anode", if_b.anode_n, 6'b111111);
    check_eq("t2_abort_done", if_b.countdown_done, 0);

    // ---- Test 3: N=4 T=2, pause 5 cycles in step 1 ----
    if_c.start = 1; tick(); if_c.start = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      check_eq($sformatf("t3_done_pulse_c%0d", c), if_c.done_pulse, (c == 13));
      if (c >= 2 && c <= 8) check_eq($sformatf("t3_idx_c%0d", c), if_c.step_idx, 1);
      if (c == 9) check_eq("t3_idx_resume", if_c.step_idx, 2);
      if (c == 5) check_eq("t3_paused", if_c.state_dbg, PAUSED);
      if (c == 8) check_eq("t3_running", if_c.state_dbg, RUN);
      if (c == 2) if_c.pause = 1;
      if (c == 7) if_c.pause = 0;
    end

    // ---- Test 4: restart at step 2, single done pulse ----
    if_a.start = 1; tick(); if_a.start = 0;
    tick(); tick();
    check_eq("t4_idx2", if_a.step_idx, 2);
    if_a.start = 1; tick(); if_a.start = 0;
    check_eq("t4_restart_idx", if_a.step_idx, 0);
    check_eq("t4_restart_act", if_a.countdown_in_action, 1);
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (if_a.done_pulse) pulses++;
      if (k < 4) check_eq($sformatf("t4_idx_k%0d", k), if_a.step_idx, k);
      if (k == 4) check_eq("t4_done_at", if_a.done_pulse, 1);
    end
    check_eq("t4_one_pulse", pulses, 1);

    // ---- Test 5: async reset mid-step, then start+abort ----
    if_b.start = 1; tick(); if_b.start = 0;
    tick(); tick(); tick(); tick();
    check_eq("t5_b_running", if_b.step_idx, 1);
    #3; rst = 1'b1; #1;
    check_eq("t5_rst_b_idx", if_b.step_idx, 0);
    check_eq("t5_rst_b_anode", if_b.anode_n, 6'b111111);
    check_eq("t5_rst_b_act", if_b.countdown_in_action, 0);
    check_eq("t5_rst_a_done", if_a.countdown_done, 0);
    check_eq("t5_rst_b_state", if_b.state_dbg, IDLE);
    #2; rst = 1'b0;
    if_a.start = 1; tick(); if_a.start = 0;
    tick();
    if_a.start = 1; if_a.abort = 1; tick(); if_a.start = 0; if_a.abort = 0;
    check_eq("t5_sa_state", if_a.state_dbg, IDLE);
    check_eq("t5_sa_idx", if_a.step_idx, 0);
    check_eq("t5_sa_act", if_a.countdown_in_action, 0);

    // ---- Test 6: start+pause on same edge ----
    if_c.start = 1; if_c.pause = 1; tick(); if_c.start = 0;
    check_eq("t6_state", if_c.state_dbg, PAUSED);
    check_eq("t6_idx", if_c.step_idx, 0);
    check_eq("t6_anode", if_c.anode_n, 4'b1110);
    check_eq("t6_act", if_c.countdown_in_action, 1);
    tick();
    check_eq("t6_frozen", if_c.step_idx, 0);
    if_c.pause = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      check_eq($sformatf("t6_done_c%0d", c), if_c.done_pulse, (c == 9));
      if (c == 3) check_eq("t6_idx1", if_c.step_idx, 1);
      if (c == 2) check_eq("t6_resumed", if_c.state_dbg, RUN);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Simple guard so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
